// File: rtl/toggle_handshake_receiver_if.sv
// Bundles the two-phase request/acknowledge link and the local valid/ready port
// of toggle_handshake_receiver; the receiver connects through the slave modport.
interface toggle_handshake_receiver_if #(
    parameter int DATA_W = 8
);
    logic              req_tgl;
    logic [DATA_W-1:0] data_in;
    logic              ack_tgl;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              proto_err;

    modport slave (
        input  req_tgl, data_in, out_ready,
        output ack_tgl, out_data, out_valid, proto_err
    );

    modport master (
        output req_tgl, data_in, out_ready,
        input  ack_tgl, out_data, out_valid, proto_err
    );
endinterface

// File: rtl/toggle_handshake_receiver.sv
// Receiver for a toggle request/acknowledge link with a one-word valid/ready output.
// Optional feature: define TOGGLE_RX_EVENT_COUNT_EN to add the 16-bit event_cnt output.
module toggle_handshake_receiver #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    toggle_handshake_receiver_if.slave bus
`ifdef TOGGLE_RX_EVENT_COUNT_EN
    ,
    output logic [15:0] event_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] req_sync_q;
    logic [SYNC_STAGES-1:0] req_sync_d;
    logic                   req_s;
    logic                   pending_s;
    state_t                 state_q;
    logic                   ack_q;
    logic                   valid_q;
    logic [DATA_W-1:0]      data_q;
    logic                   err_q;
`ifdef TOGGLE_RX_EVENT_COUNT_EN
    logic [15:0]            cnt_q;
`endif

    assign req_sync_d = {req_sync_q[SYNC_STAGES-2:0], bus.req_tgl};
    assign req_s      = req_sync_q[SYNC_STAGES-1];
    assign pending_s  = req_s ^ ack_q;

    // Synchroniser for the asynchronous request toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_sync_q <= '0;
        end else begin
            req_sync_q <= req_sync_d;
        end
    end

    // Capture/hold FSM; all outputs are registers updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef TOGGLE_RX_EVENT_COUNT_EN
            cnt_q   <= 16'h0000;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pending_s) begin
                        data_q  <= bus.data_in;
                        valid_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // A second request toggle before our ack cancels pending.
                    if (!pending_s) begin
                        err_q <= 1'b1;
                    end
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        ack_q   <= ~ack_q;
                        state_q <= ST_IDLE;
`ifdef TOGGLE_RX_EVENT_COUNT_EN
                        cnt_q   <= cnt_q + 16'h0001;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack_tgl   = ack_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.proto_err = err_q;
`ifdef TOGGLE_RX_EVENT_COUNT_EN
    assign event_cnt     = cnt_q;
`endif

endmodule

// File: tb/tb_toggle_handshake_receiver.sv
// Self-checking bench for toggle_handshake_receiver: scoreboard of expected words
// plus directed checks of latency, back-pressure, protocol error and reset.
module tb_toggle_handshake_receiver;

    localparam int DATA_W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [DATA_W-1:0] exp_q[$];

    toggle_handshake_receiver_if #(.DATA_W(DATA_W)) bus ();

`ifdef TOGGLE_RX_EVENT_COUNT_EN
    logic [15:0] event_cnt;
`endif

    toggle_handshake_receiver #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef TOGGLE_RX_EVENT_COUNT_EN
        ,
        .event_cnt(event_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted word must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    check("sb_data", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_tgl = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int budget;
        budget = 0;
        while (!bus.out_valid && budget < 20) begin
            tick();
            budget++;
        end
        if (!bus.out_valid) check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_ack(input string tag);
        int budget;
        budget = 0;
        while (bus.ack_tgl !== bus.req_tgl && budget < 20) begin
            tick();
            budget++;
        end
        if (bus.ack_tgl !== bus.req_tgl) check(tag, {31'd0, bus.ack_tgl}, {31'd0, bus.req_tgl});
    endtask

    initial begin
        int vcount;
        n_checks      = 0;
        n_errors      = 0;
        bus.req_tgl   = 1'b0;
        bus.data_in   = 8'h00;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        tick();
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_ack",   {31'd0, bus.ack_tgl},   32'd0);
        check("rst_data",  {24'd0, bus.out_data},  32'd0);
        check("rst_err",   {31'd0, bus.proto_err}, 32'd0);
        do_reset();

        // Latency: valid after edge 2 counting from the toggle, one cycle wide.
        bus.data_in   = 8'hA5;
        bus.out_ready = 1'b1;
        bus.req_tgl   = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        check("t1_e0_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("t1_e1_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("t1_e2_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t1_e2_data",  {24'd0, bus.out_data},  32'h0000_00A5);
        check("t1_e2_ack",   {31'd0, bus.ack_tgl},   32'd0);
        tick();
        check("t1_e3_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t1_e3_ack",   {31'd0, bus.ack_tgl},   32'd1);

        // Back-pressure: word and ack stay put while out_ready is low.
        do_reset();
        bus.out_ready = 1'b0;
        bus.data_in   = 8'h3C;
        bus.req_tgl   = 1'b1;
        exp_q.push_back(8'h3C);
        wait_valid("t2_timeout");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_valid", {31'd0, bus.out_valid}, 32'd1);
            check("t2_data",  {24'd0, bus.out_data},  32'h0000_003C);
            check("t2_ack",   {31'd0, bus.ack_tgl},   32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("t2_ack_flip",  {31'd0, bus.ack_tgl},   32'd1);
        check("t2_valid_end", {31'd0, bus.out_valid}, 32'd0);

        // Four transfers, each started once the previous ack has arrived.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.data_in = DATA_W'(i);
            bus.req_tgl = ~bus.req_tgl;
            exp_q.push_back(DATA_W'(i));
            wait_ack("t3_timeout");
        end
        tick();
        check("t3_ack", {31'd0, bus.ack_tgl},   32'd0);
        check("t3_err", {31'd0, bus.proto_err}, 32'd0);
        check("t3_sb",  exp_q.size(),           32'd0);
`ifdef TOGGLE_RX_EVENT_COUNT_EN
        check("t3_cnt", {16'd0, event_cnt},     32'd4);
`endif

        // Double toggle while holding: sticky protocol error, word kept.
        do_reset();
        bus.out_ready = 1'b0;
        bus.data_in   = 8'h5A;
        bus.req_tgl   = 1'b1;
        wait_valid("t4_timeout");
        tick();
        tick();
        bus.req_tgl = 1'b0;
        repeat (5) tick();
        check("t4_err",   {31'd0, bus.proto_err}, 32'd1);
        check("t4_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t4_data",  {24'd0, bus.out_data},  32'h0000_005A);
        repeat (5) tick();
        check("t4_sticky", {31'd0, bus.proto_err}, 32'd1);

        // One-cycle reset mid-hold drops the word; nothing follows.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t5_ack",   {31'd0, bus.ack_tgl},   32'd0);
        check("t5_err",   {31'd0, bus.proto_err}, 32'd0);
        bus.out_ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_valid) vcount++;
        end
        check("t5_spurious", vcount, 32'd0);

`ifdef TOGGLE_RX_EVENT_COUNT_EN
        // Counter wrap from 16'hFFFF.
        force dut.cnt_q = 16'hFFFF;
        tick();
        release dut.cnt_q;
        check("t6_preload", {16'd0, event_cnt}, 32'h0000_FFFF);
        bus.data_in = 8'h77;
        bus.req_tgl = ~bus.req_tgl;
        exp_q.push_back(8'h77);
        wait_ack("t6_timeout");
        tick();
        check("t6_wrap", {16'd0, event_cnt}, 32'd0);
`endif

        repeat (3) tick();
        check("sb_left", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
